cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/req_fifo2.sv | 66 ++++++
 rtl/cpu_mem_responder.sv | 131 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
package cpu_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Word returned on an address miss
    localparam logic [29:0] MissData = 30'h3FFF_FFFF;

    // Table geometry
    localparam int unsigned TableDepth = 16;
    localparam int unsigned IdxWidth   = 4;

endpackage

// File: rtl/req_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; push is refused only when full
// at the start of the cycle, even if a pop happens in the same cycle.
module req_fifo2 #(
    parameter int unsigned Width = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             ready_o,
    output logic             empty_o,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    assign ready_o = (count_q != 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rptr_q];

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ~wptr_q;
        end
        if (pop_ok) begin
            rptr_d = ~rptr_q;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Word-read responder: queues CPU requests, inserts wait states, then answers
// from a 16-entry writable table when the address falls in its window.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [29:0] BASE_ADDR   = 30'h2100_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [29:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [29:0] rsp_data,
    output logic        rsp_err,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_idx,
    input  logic [29:0] cfg_data
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [29:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [29:0] table_q [TableDepth];
    logic [29:0] table_d [TableDepth];

    logic        fifo_ready, fifo_empty, fifo_pop;
    logic [29:0] fifo_head;
    logic [29:0] lookup_addr;

    req_fifo2 #(
        .Width (30)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (req_valid),
        .data_i  (req_addr),
        .pop_i   (fifo_pop),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty),
        .data_o  (fifo_head)
    );

    assign req_ready = fifo_ready;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // FSM next-state; lookup uses the FIFO head directly when skipping WAIT
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        fifo_pop    = 1'b0;
        lookup_addr = addr_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    addr_d      = fifo_head;
                    lookup_addr = fifo_head;
                    wait_cnt_d  = WaitInit;
                    state_d     = (WaitInit == 4'd0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (wait_cnt_q <= 4'd1) begin
                    wait_cnt_d = 4'd0;
                    state_d    = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response capture on the edge entering RESP; zero otherwise
    always_comb begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        if (state_d == StResp) begin
            if (lookup_addr[29:4] == BASE_ADDR[29:4]) begin
                rsp_data_d = table_q[lookup_addr[3:0]];
            end else begin
                rsp_data_d = MissData;
                rsp_err_d  = 1'b1;
            end
        end
    end

    // Table write; capture above reads table_q so same-edge writes return old data
    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            table_d[cfg_idx] = cfg_data;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < TableDepth; i++) begin
                table_q[i] <= BASE_ADDR + 30'(i);
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            table_q    <= table_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised bench for cpu_mem_responder: two instances (WAIT_CYCLES 2 and 0)
// share stimulus and are each checked against a transaction-level model.
module tb_cpu_mem_responder;

    localparam logic [29:0] Base = 30'h2100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [29:0] req_addr;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [29:0] cfg_data;

    logic        rdy0, vld0, err0, rdy1, vld1, err1;
    logic [29:0] dat0, dat1;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .WAIT_CYCLES (2),
        .BASE_ADDR   (Base)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (rdy0),
        .rsp_valid (vld0),
        .rsp_data  (dat0),
        .rsp_err   (err0),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data)
    );

    cpu_mem_responder #(
        .WAIT_CYCLES (0),
        .BASE_ADDR   (Base)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (rdy1),
        .rsp_valid (vld1),
        .rsp_data  (dat1),
        .rsp_err   (err1),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: per instance, a list of accepted requests with service-start (pop)
    // cycle and response cycle, plus a shadow copy of the table.
    int          wcyc [2] = '{2, 0};
    logic [29:0] mtab [16];
    int          p_s    [2][8];
    int          p_r    [2][8];
    logic [29:0] p_addr [2][8];
    logic [29:0] p_dat  [2][8];
    logic        p_err  [2][8];
    int          p_head [2];
    int          p_cnt  [2];
    int          last_resp [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            p_head[d]    = 0;
            p_cnt[d]     = 0;
            last_resp[d] = -100;
        end
        for (int i = 0; i < 16; i++) mtab[i] = Base + 30'(i);
    endtask

    // FIFO has room when fewer than two accepted requests are still unpopped
    function automatic bit model_ready(input int d, input int c);
        int n = 0;
        for (int k = 0; k < p_cnt[d]; k++) begin
            if (p_s[d][(p_head[d] + k) % 8] >= c) n++;
        end
        return n < 2;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (req_valid && model_ready(d, cyc)) begin
                int slot = (p_head[d] + p_cnt[d]) % 8;
                int s = (cyc + 1 > last_resp[d] + 1) ? cyc + 1 : last_resp[d] + 1;
                p_s[d][slot]    = s;
                p_r[d][slot]    = s + 1 + wcyc[d];
                p_addr[d][slot] = req_addr;
                p_cnt[d]++;
                last_resp[d]    = s + 1 + wcyc[d];
            end
            for (int k = 0; k < p_cnt[d]; k++) begin
                int slot = (p_head[d] + k) % 8;
                if (p_r[d][slot] == cyc + 1) begin
                    if (p_addr[d][slot][29:4] == Base[29:4]) begin
                        p_dat[d][slot] = mtab[p_addr[d][slot][3:0]];
                        p_err[d][slot] = 1'b0;
                    end else begin
                        p_dat[d][slot] = 30'h3FFF_FFFF;
                        p_err[d][slot] = 1'b1;
                    end
                end
            end
            while (p_cnt[d] > 0 && p_r[d][p_head[d]] <= cyc) begin
                p_head[d] = (p_head[d] + 1) % 8;
                p_cnt[d]--;
            end
        end
        if (cfg_we) mtab[cfg_idx] = cfg_data;
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic        ev = 1'b0;
            logic [29:0] edat = '0;
            logic        eerr = 1'b0;
            for (int k = 0; k < p_cnt[d]; k++) begin
                int slot = (p_head[d] + k) % 8;
                if (p_r[d][slot] == cyc) begin
                    ev   = 1'b1;
                    edat = p_dat[d][slot];
                    eerr = p_err[d][slot];
                end
            end
            check_eq($sformatf("d%0d req_ready", d), {31'd0, d == 0 ? rdy0 : rdy1},
                     {31'd0, model_ready(d, cyc)});
            check_eq($sformatf("d%0d rsp_valid", d), {31'd0, d == 0 ? vld0 : vld1}, {31'd0, ev});
            check_eq($sformatf("d%0d rsp_data", d), {2'd0, d == 0 ? dat0 : dat1}, {2'd0, edat});
            check_eq($sformatf("d%0d rsp_err", d), {31'd0, d == 0 ? err0 : err1}, {31'd0, eerr});
        end
    endtask

    task automatic run_cycle(input logic rv, input logic [29:0] a, input logic we,
                             input logic [3:0] idx, input logic [29:0] wd);
        req_valid = rv;
        req_addr  = a;
        cfg_we    = we;
        cfg_idx   = idx;
        cfg_data  = wd;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, 4'd0, '0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst rdy0", {31'd0, rdy0}, 32'd1);
        check_eq("rst vld0", {31'd0, vld0}, 32'd0);
        check_eq("rst dat0", {2'd0, dat0}, 32'd0);
        check_eq("rst err0", {31'd0, err0}, 32'd0);
        check_eq("rst rdy1", {31'd0, rdy1}, 32'd1);
        check_eq("rst vld1", {31'd0, vld1}, 32'd0);
        check_eq("rst dat1", {2'd0, dat1}, 32'd0);
        check_eq("rst err1", {31'd0, err1}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_data  = '0;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: hit, miss, back-to-back burst, cfg write then read
        run_cycle(1'b1, 30'h2100_0003, 1'b0, 4'd0, '0);
        idle(6);
        run_cycle(1'b1, 30'h2100_0010, 1'b0, 4'd0, '0);
        idle(6);
        run_cycle(1'b1, 30'h2100_0001, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_0007, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_000F, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_0002, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_0004, 1'b0, 4'd0, '0);
        idle(20);
        run_cycle(1'b0, '0, 1'b1, 4'd5, 30'h0ABC_DEF0);
        run_cycle(1'b1, 30'h2100_0005, 1'b0, 4'd0, '0);
        idle(6);
        // Write landing on the capture edge of the slow instance
        run_cycle(1'b1, 30'h2100_0005, 1'b0, 4'd0, '0);
        idle(2);
        run_cycle(1'b0, '0, 1'b1, 4'd5, 30'h0123_4567);
        idle(6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [29:0] a;
            int sel = $urandom_range(0, 3);
            if (sel <= 1)      a = Base + 30'($urandom_range(0, 15));
            else if (sel == 2) a = Base + 30'd16 + 30'($urandom_range(0, 15));
            else               a = 30'($urandom);
            run_cycle(($urandom_range(0, 1) == 1), a, ($urandom_range(0, 3) == 0),
                      4'($urandom_range(0, 15)), 30'($urandom));
        end
        idle(12);

        // Asynchronous reset mid-cycle while requests are queued and in flight
        run_cycle(1'b1, 30'h2100_0001, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_0002, 1'b0, 4'd0, '0);
        run_cycle(1'b1, 30'h2100_0003, 1'b0, 4'd0, '0);
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
